// File: rtl/dyser_fifo_pkg.sv
// Shared definitions for the dyser output-side FIFO: default widths, credit
// margin and the ceiling-log2 helper used to size pointers and counters.
package dyser_fifo_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int DATA_W_DEF        = DATA_WIDTH + 1;
    localparam int CREDIT_MARGIN_DEF = 2;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value)
            res++;
        return res;
    endfunction

    // Per-cycle decode of the request pins.
    typedef struct packed {
        logic bypass;
        logic push;
        logic pop;
        logic busy;
        logic under;
    } fifo_ctl_t;

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset,
// so it maps onto distributed RAM / LUTRAM.
module fifo_ram_sdp
    import dyser_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_dyser_out_gen.sv
// First-word-fall-through FIFO feeding the dyser output bridge, with
// empty-bypass, full-with-dequeue pass-through, credit output and sticky
// overflow/underflow flags.
module fifo_dyser_out_gen
    import dyser_fifo_pkg::*;
#(
    parameter int ID            = 0,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int DEPTH         = 512,
    parameter int CREDIT_MARGIN = CREDIT_MARGIN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        d_in,
    input  logic                     enq,
    input  logic                     deq,
    output logic [DATA_W-1:0]        d_out,
    output logic                     empty,
    output logic                     full,
    output logic                     valid,
    output logic                     busy,
    output logic                     c_out,
    output logic [clog2(DEPTH):0]    count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_CREDIT = CNT_W'(DEPTH - CREDIT_MARGIN);

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
            CREDIT_MARGIN < 1 || CREDIT_MARGIN >= DEPTH || ID < 0) begin : g_bad_params
            $fatal(1, "fifo_dyser_out_gen: illegal parameter set");
        end
    endgenerate

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] ram_rdata;
    fifo_ctl_t         ctl;

    // Flags come only from the registered count, never from enq/deq.
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign c_out = (count <= CNT_CREDIT) & ~full;

    always_comb begin
        ctl        = '0;
        ctl.bypass = enq & deq & empty;
        ctl.pop    = deq & ~empty;
        ctl.push   = enq & ~ctl.bypass & (~full | deq);
        ctl.busy   = enq & full & ~deq;
        ctl.under  = deq & empty & ~enq;
    end

    assign valid = deq & (~empty | enq);
    assign busy  = ctl.busy;
    assign d_out = ctl.bypass ? d_in : ram_rdata;

    fifo_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (ctl.push),
        .waddr  (wr_ptr),
        .wdata  (d_in),
        .raddr  (rd_ptr),
        .rdata  (ram_rdata)
    );

    // Power-of-two depth: pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (ctl.push)
                wr_ptr <= wr_ptr + AW'(1);
            if (ctl.pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({ctl.push, ctl.pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ctl.busy)
                ovf <= 1'b1;
            if (ctl.under)
                udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_dyser_out_gen.sv
// Directed + short random bench for fifo_dyser_out_gen at DEPTH=4,
// CREDIT_MARGIN=2, with a queue scoreboard of expected output words.
module tb_fifo_dyser_out_gen;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CM    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] d_in;
    logic          enq;
    logic          deq;
    logic [DW-1:0] d_out;
    logic          empty;
    logic          full;
    logic          valid;
    logic          busy;
    logic          c_out;
    logic [2:0]    count;
    logic          ovf;
    logic          udf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb[$];
    logic          m_ovf;
    logic          m_udf;

    fifo_dyser_out_gen #(
        .ID            (0),
        .DATA_W        (DW),
        .DEPTH         (DEPTH),
        .CREDIT_MARGIN (CM)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .enq   (enq),
        .deq   (deq),
        .d_out (d_out),
        .empty (empty),
        .full  (full),
        .valid (valid),
        .busy  (busy),
        .c_out (c_out),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        int n;
        n = sb.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full",  32'(full),  32'(n == DEPTH));
        chk("c_out", 32'(c_out), 32'((n <= DEPTH - CM) && (n != DEPTH)));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        chk("udf",   32'(udf),   32'(m_udf));
    endtask

    // One clock: drive, check combinational outputs mid-cycle, update the
    // scoreboard the way the FIFO should, clock, then check registered state.
    task automatic cyc(input logic e, input logic q, input logic [DW-1:0] d);
        logic          m_empty, m_full, exp_valid;
        logic [DW-1:0] exp_word;
        enq = e; deq = q; d_in = d;
        #2;
        m_empty   = (sb.size() == 0);
        m_full    = (sb.size() == DEPTH);
        exp_valid = q & (~m_empty | e);
        chk("valid", 32'(valid), 32'(exp_valid));
        chk("busy",  32'(busy),  32'(e & m_full & ~q));
        if (exp_valid) begin
            exp_word = m_empty ? d : sb.pop_front();
            chk("d_out", 32'(d_out), 32'(exp_word));
        end
        if (e && !(q && m_empty) && (!m_full || q))
            sb.push_back(d);
        if (e && m_full && !q) m_ovf = 1'b1;
        if (q && m_empty && !e) m_udf = 1'b1;
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0;
        chk_state();
    endtask

    task automatic do_reset(input logic e, input logic q);
        rst = 1'b1; enq = e; deq = q; d_in = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0; enq = 1'b0; deq = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk_state();
    endtask

    initial begin
        rst = 1'b1; enq = 1'b0; deq = 1'b0; d_in = '0;
        m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk);
        do_reset(1'b0, 1'b0);
        chk("busy_rst", 32'(busy), 32'(0));

        // empty bypass
        cyc(1'b1, 1'b1, 8'hA5);

        // fill to full, c_out drops at count 3
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 1'b0, DW'(i));
        cyc(1'b1, 1'b0, 8'h05);

        // full pass-through, then drain
        cyc(1'b1, 1'b1, 8'h09);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 8'h00);

        // occupancy-one streaming across pointer wrap
        cyc(1'b1, 1'b0, 8'h10);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, DW'(8'h11 + i));
        cyc(1'b0, 1'b1, 8'h00);

        // underflow, cleared by reset
        cyc(1'b0, 1'b1, 8'h00);
        do_reset(1'b0, 1'b0);

        // reset with data stored and enq asserted discards everything
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, DW'(8'h30 + i));
        do_reset(1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        do_reset(1'b0, 1'b0);

        // random mix
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_dyser_out_gen.md
FIFO_DYSER_OUT_GEN -- requirements
Module: fifo_dyser_out_gen

Interface
REQ-001 Parameter: ID, 0, instance identifier; no functional effect.
REQ-002 Parameter: DATA_W, `DATA_WIDTH+1, word width in bits.
REQ-003 Parameter: DEPTH, 512, storage entries; power of two, minimum 4.
REQ-004 Parameter: CREDIT_MARGIN, 2, free entries below which c_out drops; range 1..DEPTH-1.
REQ-005 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 Port: rst  in  1  reset; synchronous, active-high.
REQ-007 Port: d_in  in  DATA_W  write data.
REQ-008 Port: enq  in  1  enqueue request.
REQ-009 Port: deq  in  1  dequeue request from the core.
REQ-010 Port: d_out  out  DATA_W  head word or bypassed d_in.
REQ-011 Port: empty  out  1  storage holds zero entries.
REQ-012 Port: full  out  1  storage holds DEPTH entries.
REQ-013 Port: valid  out  1  d_out carries a word consumed this cycle.
REQ-014 Port: busy  out  1  enqueue rejected this cycle.
REQ-015 Port: c_out  out  1  credit to the output bridge; room for at least CREDIT_MARGIN more words.
REQ-016 Port: count  out  clog2(DEPTH)+1  current occupancy.
REQ-017 Port: ovf  out  1  sticky overflow flag.
REQ-018 Port: udf  out  1  sticky underflow flag.

Function
REQ-019 The block SHALL define internal terms: bypass = enq & deq & empty; pop = deq & ~empty; push = enq & ~bypass & (~full | deq).
REQ-020 The block SHALL drive d_out combinationally: d_in when bypass, otherwise mem[rd_ptr] (first-word-fall-through, zero read latency).
REQ-021 The block SHALL drive valid = deq & (~empty | enq).
REQ-022 The block SHALL drive busy = enq & full & ~deq; on a busy cycle d_in is dropped and no state changes except ovf.
REQ-023 On push it SHALL write d_in to mem[wr_ptr] and advance wr_ptr modulo DEPTH; on pop it SHALL advance rd_ptr modulo DEPTH.
REQ-024 count SHALL update the cycle after the request: +1 if push & ~pop; -1 if pop & ~push; unchanged otherwise, including bypass.
REQ-025 With full & enq & deq, the block SHALL pop the head and write d_in in the same cycle; count stays DEPTH and no data is lost.
REQ-026 With ~empty & enq & deq, d_out SHALL be the old head; d_in is appended at the tail.
REQ-027 empty SHALL be (count == 0) and full SHALL be (count == DEPTH), both registered-derived with no combinational path from enq or deq.
REQ-028 c_out SHALL be (count <= DEPTH - CREDIT_MARGIN) & ~full, derived from registered count only.
REQ-029 ovf SHALL set on any busy cycle; udf SHALL set on deq & empty & ~enq; both hold until rst.
REQ-030 A word written at cycle N SHALL be visible on d_out at cycle N+1 when it is the head.
REQ-031 Pointer wrap SHALL be seamless; ordering is strictly FIFO across wrap.

Reset
REQ-032 While rst is high at a clock edge, wr_ptr, rd_ptr and count SHALL clear to 0, and ovf and udf SHALL clear to 0.
REQ-033 After reset: empty=1, full=0, c_out=1, count=0, valid=deq&enq, busy=0.
REQ-034 Reset mid-operation SHALL discard all stored words; the array contents are not cleared.
REQ-035 rst SHALL take priority over enq and deq in the same cycle.

Structure
REQ-036 DATA_W default, the clog2 function and CREDIT_MARGIN default SHALL reside in the shared package dyser_fifo_pkg.
REQ-037 Storage SHALL be one sub-module, fifo_ram_sdp: a simple dual-port RAM with synchronous write and asynchronous read, inferable as distributed RAM or LUTRAM.
REQ-038 No vendor FIFO IP SHALL be instantiated.

Verification (DEPTH=4, CREDIT_MARGIN=2)
REQ-039 Reset, then enq=deq=1 with d_in=0xA5 while empty -> d_out=0xA5, valid=1, count stays 0.
REQ-040 Push 0x1,0x2,0x3,0x4 -> count=4, full=1, c_out=0 once count reaches 3; a 5th enq without deq -> busy=1, ovf=1, count=4.
REQ-041 While full, enq=deq=1 with d_in=0x9 -> d_out=0x1, count=4; the next four pops return 0x2,0x3,0x4,0x9.
REQ-042 Ten push/pop cycles at one entry of occupancy -> pointers wrap and data order is preserved.
REQ-043 deq=1, enq=0 while empty -> valid=0, udf=1; a subsequent rst -> udf=0.
REQ-044 rst asserted with count=3 and enq=1 -> the next cycle shows count=0, empty=1, and the stored data is not returned.
